// File: rtl/core_lsu_wbuf_pkg.sv
// Shared types and helpers for the LSU store write buffer.
package core_lsu_wbuf_pkg;

  // One buffered store as it will be replayed to the dram manager.
  typedef struct packed {
    logic [31:0] paddr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic        uncached;
    logic [1:0]  size;
  } wbuf_entry_t;

  // Result of a load probe against the buffer.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
    logic        conflict;
  } wbuf_lkup_t;

  // Overwrite the byte lanes selected by strb with the new word's lanes.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/core_lsu_wbuf_fwd.sv
// Byte-lane store-to-load forwarding over an age-ordered entry array
// (index 0 oldest), plus the load-stall decision.
module core_lsu_wbuf_fwd
  import core_lsu_wbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wbuf_entry_t      ent_i [DEPTH],
  input  logic [DEPTH-1:0] age_vld_i,
  input  logic             lkup_valid_i,
  input  logic [31:0]      lkup_paddr_i,
  input  logic             lkup_uncached_i,
  output wbuf_lkup_t       res_o
);

  // Walk oldest to youngest so younger matching bytes override older ones.
  always_comb begin
    res_o = '0;
    if (lkup_valid_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (age_vld_i[k]) begin
          if (ent_i[k].uncached) begin
            res_o.conflict = 1'b1;
          end else if (ent_i[k].paddr[31:2] == lkup_paddr_i[31:2]) begin
            for (int b = 0; b < 4; b++) begin
              if (ent_i[k].strobe[b]) begin
                res_o.data[8*b +: 8] = ent_i[k].wdata[8*b +: 8];
                res_o.mask[b]        = 1'b1;
              end
            end
          end
        end
      end
      if (lkup_uncached_i && (|age_vld_i)) res_o.conflict = 1'b1;
    end
  end

endmodule

// File: rtl/core_lsu_wbuf.sv
// LSU store write buffer: circular FIFO of stores between M2 and the dram
// manager, with same-word byte coalescing and load forwarding.
module core_lsu_wbuf
  import core_lsu_wbuf_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int COALESCE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid_i,
  output logic                       push_ready_o,
  input  logic [31:0]                push_paddr_i,
  input  logic [31:0]                push_wdata_i,
  input  logic [3:0]                 push_strobe_i,
  input  logic                       push_uncached_i,
  input  logic [1:0]                 push_size_i,
  output logic                       drain_valid_o,
  input  logic                       drain_ready_i,
  output logic [31:0]                drain_paddr_o,
  output logic [31:0]                drain_wdata_o,
  output logic [3:0]                 drain_strobe_o,
  output logic                       drain_uncached_o,
  output logic [1:0]                 drain_size_o,
  input  logic                       lkup_valid_i,
  input  logic [31:0]                lkup_paddr_i,
  input  logic                       lkup_uncached_i,
  output logic [31:0]                lkup_data_o,
  output logic [3:0]                 lkup_mask_o,
  output logic                       lkup_conflict_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wbuf_entry_t      ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] head_q, tail_q, young;
  logic [CNT_W-1:0] count_q, count_d;
  logic             coal_hit, push_acc, push_new, drain_fire;
  wbuf_entry_t      push_ent, head_ent;
  wbuf_entry_t      age_ent [DEPTH];
  logic [DEPTH-1:0] age_vld;
  wbuf_lkup_t       lkup_res;

  assign young = tail_q - PTR_W'(1);

  // count >= 2 keeps the merge target away from the head, so a stalled
  // drain payload is never modified underneath the dram manager.
  assign coal_hit = (COALESCE != 0) && !push_uncached_i &&
                    (count_q >= CNT_W'(2)) && !ent_q[young].uncached &&
                    (ent_q[young].paddr[31:2] == push_paddr_i[31:2]);

  assign push_ready_o  = (count_q != CNT_W'(DEPTH)) || coal_hit;
  assign push_acc      = push_valid_i && push_ready_o;
  assign push_new      = push_acc && !coal_hit;
  assign drain_valid_o = (count_q != '0);
  assign drain_fire    = drain_valid_o && drain_ready_i && !rst;
  assign count_d       = count_q + CNT_W'(push_new) - CNT_W'(drain_fire);

  assign push_ent = '{paddr: push_paddr_i, wdata: push_wdata_i, strobe: push_strobe_i,
                      uncached: push_uncached_i, size: push_size_i};
  assign head_ent = ent_q[head_q];

  assign drain_paddr_o    = drain_valid_o ? head_ent.paddr    : '0;
  assign drain_wdata_o    = drain_valid_o ? head_ent.wdata    : '0;
  assign drain_strobe_o   = drain_valid_o ? head_ent.strobe   : '0;
  assign drain_uncached_o = drain_valid_o ? head_ent.uncached : 1'b0;
  assign drain_size_o     = drain_valid_o ? head_ent.size     : '0;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Rotate storage so the forwarding unit sees entries oldest-first.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_ent[k] = ent_q[head_q + PTR_W'(k)];
      age_vld[k] = vld_q[head_q + PTR_W'(k)];
    end
  end

  core_lsu_wbuf_fwd #(.DEPTH(DEPTH)) u_fwd (
    .ent_i           (age_ent),
    .age_vld_i       (age_vld),
    .lkup_valid_i    (lkup_valid_i),
    .lkup_paddr_i    (lkup_paddr_i),
    .lkup_uncached_i (lkup_uncached_i),
    .res_o           (lkup_res)
  );

  assign lkup_data_o     = lkup_res.data;
  assign lkup_mask_o     = lkup_res.mask;
  assign lkup_conflict_o = lkup_res.conflict;

  // Pointer/count bookkeeping, new-entry writes and youngest-entry merges.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i].strobe <= '0;
    end else begin
      if (drain_fire) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + PTR_W'(1);
      end
      if (push_new) begin
        ent_q[tail_q] <= push_ent;
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PTR_W'(1);
      end else if (push_acc) begin
        ent_q[young].wdata  <= merge_bytes(ent_q[young].wdata, push_wdata_i, push_strobe_i);
        ent_q[young].strobe <= ent_q[young].strobe | push_strobe_i;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_core_lsu_wbuf.sv
// Directed bench for the LSU store write buffer (DEPTH=4, coalescing on).
module tb_core_lsu_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid_i, push_ready_o;
  logic [31:0] push_paddr_i, push_wdata_i;
  logic [3:0]  push_strobe_i;
  logic        push_uncached_i;
  logic [1:0]  push_size_i;
  logic        drain_valid_o, drain_ready_i;
  logic [31:0] drain_paddr_o, drain_wdata_o;
  logic [3:0]  drain_strobe_o;
  logic        drain_uncached_o;
  logic [1:0]  drain_size_o;
  logic        lkup_valid_i;
  logic [31:0] lkup_paddr_i;
  logic        lkup_uncached_i;
  logic [31:0] lkup_data_o;
  logic [3:0]  lkup_mask_o;
  logic        lkup_conflict_o;
  logic        empty_o;
  logic [2:0]  count_o;

  int n_chk = 0;
  int n_err = 0;

  core_lsu_wbuf #(.DEPTH(4), .COALESCE(1)) dut (
    .clk(clk), .rst(rst),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_paddr_i(push_paddr_i), .push_wdata_i(push_wdata_i),
    .push_strobe_i(push_strobe_i), .push_uncached_i(push_uncached_i),
    .push_size_i(push_size_i),
    .drain_valid_o(drain_valid_o), .drain_ready_i(drain_ready_i),
    .drain_paddr_o(drain_paddr_o), .drain_wdata_o(drain_wdata_o),
    .drain_strobe_o(drain_strobe_o), .drain_uncached_o(drain_uncached_o),
    .drain_size_o(drain_size_o),
    .lkup_valid_i(lkup_valid_i), .lkup_paddr_i(lkup_paddr_i),
    .lkup_uncached_i(lkup_uncached_i),
    .lkup_data_o(lkup_data_o), .lkup_mask_o(lkup_mask_o),
    .lkup_conflict_o(lkup_conflict_o),
    .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic u, input logic [1:0] sz);
    push_valid_i = 1'b1; push_paddr_i = a; push_wdata_i = d;
    push_strobe_i = s; push_uncached_i = u; push_size_i = sz;
    #1;
    check("push_ready", 32'(push_ready_o), 32'd1);
    @(posedge clk); #1;
    push_valid_i = 1'b0;
  endtask

  task automatic drain_one();
    drain_ready_i = 1'b1;
    #1;
    check("drain_valid", 32'(drain_valid_o), 32'd1);
    @(posedge clk); #1;
    drain_ready_i = 1'b0;
  endtask

  task automatic drain_all();
    drain_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (count_o == 3'd0) break;
      @(posedge clk); #1;
    end
    drain_ready_i = 1'b0;
    check("drain_all_count", 32'(count_o), 32'd0);
  endtask

  task automatic look(input logic [31:0] a, input logic u, input logic [31:0] ed,
                      input logic [3:0] em, input logic ec);
    lkup_valid_i = 1'b1; lkup_paddr_i = a; lkup_uncached_i = u;
    #1;
    check("lk_data", lkup_data_o, ed);
    check("lk_mask", 32'(lkup_mask_o), 32'(em));
    check("lk_conflict", 32'(lkup_conflict_o), 32'(ec));
    lkup_valid_i = 1'b0; lkup_uncached_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    push_valid_i = 0; push_paddr_i = 0; push_wdata_i = 0; push_strobe_i = 0;
    push_uncached_i = 0; push_size_i = 0; drain_ready_i = 0;
    lkup_valid_i = 0; lkup_paddr_i = 0; lkup_uncached_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_dvalid", 32'(drain_valid_o), 32'd0);
    check("rst_pready", 32'(push_ready_o), 32'd1);
    check("rst_dpaddr", drain_paddr_o, 32'd0);

    // Coalescing into the youngest entry
    push(32'h1000, 32'h11223344, 4'hF, 1'b0, 2'd2);
    push(32'h2000, 32'h00005566, 4'h3, 1'b0, 2'd1);
    push(32'h2000, 32'hAABB0000, 4'hC, 1'b0, 2'd1);
    check("coal_count", 32'(count_o), 32'd2);
    check("head_paddr", drain_paddr_o, 32'h1000);
    check("head_wdata", drain_wdata_o, 32'h11223344);
    look(32'h2000, 1'b0, 32'hAABB5566, 4'hF, 1'b0);
    lkup_valid_i = 1'b0; lkup_paddr_i = 32'h2000;
    #1;
    check("lk_off_data", lkup_data_o, 32'd0);
    check("lk_off_mask", 32'(lkup_mask_o), 32'd0);
    drain_one();
    check("b_strobe", 32'(drain_strobe_o), 32'hF);
    check("b_wdata", drain_wdata_o, 32'hAABB5566);
    check("b_count", 32'(count_o), 32'd1);
    drain_all();

    // Full buffer and drain pulse
    for (int i = 0; i < 4; i++) push(32'h4000 + 32'(4*i), 32'(i+1), 4'hF, 1'b0, 2'd2);
    check("full_count", 32'(count_o), 32'd4);
    push_valid_i = 1'b0; push_uncached_i = 1'b0; push_paddr_i = 32'h400C;
    #1;
    check("full_coal_ready", 32'(push_ready_o), 32'd1);
    push_paddr_i = 32'h5000; drain_ready_i = 1'b1;
    #1;
    check("pulse_ready", 32'(push_ready_o), 32'd0);
    @(posedge clk); #1;
    drain_ready_i = 1'b0;
    check("after_pulse_ready", 32'(push_ready_o), 32'd1);
    check("after_pulse_count", 32'(count_o), 32'd3);
    drain_ready_i = 1'b1;
    push(32'h5000, 32'h55555555, 4'h1, 1'b0, 2'd0);
    drain_ready_i = 1'b0;
    check("simul_count", 32'(count_o), 32'd3);
    drain_ready_i = 1'b1;
    push(32'h5000, 32'h77000000, 4'h8, 1'b0, 2'd0);
    drain_ready_i = 1'b0;
    check("simul_coal_count", 32'(count_o), 32'd2);
    look(32'h5000, 1'b0, 32'h77000055, 4'h9, 1'b0);

    // Stalled head stays put
    for (int i = 0; i < 5; i++) begin
      check("stall_paddr", drain_paddr_o, 32'h400C);
      check("stall_wdata", drain_wdata_o, 32'd4);
      check("stall_valid", 32'(drain_valid_o), 32'd1);
      @(posedge clk); #1;
    end
    drain_all();

    // Uncached entries and forwarding
    push(32'h3000, 32'h01020304, 4'hF, 1'b0, 2'd2);
    push(32'h3000, 32'hDEADBEEF, 4'hF, 1'b1, 2'd2);
    check("unc_no_coal_count", 32'(count_o), 32'd2);
    lkup_valid_i = 1'b1; lkup_paddr_i = 32'h3000; lkup_uncached_i = 1'b0;
    #1;
    check("unc_conflict", 32'(lkup_conflict_o), 32'd1);
    lkup_valid_i = 1'b0;
    drain_one();
    push(32'h3000, 32'h01020304, 4'hF, 1'b0, 2'd2);
    check("unc_head", 32'(drain_uncached_o), 32'd1);
    check("unc_size", 32'(drain_size_o), 32'd2);
    check("unc_wdata", drain_wdata_o, 32'hDEADBEEF);
    drain_one();
    look(32'h3000, 1'b0, 32'h01020304, 4'hF, 1'b0);
    look(32'h3000, 1'b1, 32'h01020304, 4'hF, 1'b1);
    push_valid_i = 1'b1; push_paddr_i = 32'h3000; push_wdata_i = 32'h000000AA;
    push_strobe_i = 4'h1; push_uncached_i = 1'b0; push_size_i = 2'd0;
    lkup_valid_i = 1'b1; lkup_paddr_i = 32'h3000;
    #1;
    check("same_cycle_data", lkup_data_o, 32'h01020304);
    @(posedge clk); #1;
    push_valid_i = 1'b0;
    check("fwd_lane0_data", lkup_data_o, 32'h010203AA);
    check("fwd_lane0_mask", 32'(lkup_mask_o), 32'hF);
    check("fwd_lane0_count", 32'(count_o), 32'd2);
    lkup_valid_i = 1'b0;
    drain_all();

    // Reset with a stalled head
    push(32'h6000, 32'h1, 4'hF, 1'b0, 2'd2);
    push(32'h6004, 32'h2, 4'hF, 1'b0, 2'd2);
    push(32'h6008, 32'h3, 4'hF, 1'b0, 2'd2);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_count", 32'(count_o), 32'd3);
    rst = 1'b1; drain_ready_i = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_count", 32'(count_o), 32'd0);
    check("mid_rst_dvalid", 32'(drain_valid_o), 32'd0);
    check("mid_rst_empty", 32'(empty_o), 32'd1);
    check("mid_rst_pready", 32'(push_ready_o), 32'd1);
    check("mid_rst_dpaddr", drain_paddr_o, 32'd0);
    rst = 1'b0; drain_ready_i = 1'b0;
    push(32'h7000, 32'h9, 4'hF, 1'b0, 2'd2);
    check("post_rst_count", 32'(count_o), 32'd1);
    check("post_rst_paddr", drain_paddr_o, 32'h7000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/core_lsu_wbuf.md
CORE_LSU_WBUF -- requirements
Module: core_lsu_wbuf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered store entries (power of two, 2..16).
REQ-002 SHALL have parameter COALESCE, default 1, enables byte-merging of cached stores to the same word.
REQ-003 SHALL have ports `clk` (in, 1, sole clock) and `rst` (in, 1, synchronous active-high reset).
REQ-004 SHALL have ports:
- `push_valid_i` (in, 1): store offered from M2.
- `push_ready_o` (out, 1): store accepted when both high at posedge.
- `push_paddr_i` (in, 32), `push_wdata_i` (in, 32, already lane-shifted), `push_strobe_i` (in, 4), `push_uncached_i` (in, 1), `push_size_i` (in, 2).
REQ-005 SHALL have ports:
- `drain_valid_o` (out, 1), `drain_ready_i` (in, 1): write handshake towards dram manager.
- Drain payload: `drain_paddr_o` (out, 32), `drain_wdata_o` (out, 32), `drain_strobe_o` (out, 4), `drain_uncached_o` (out, 1), `drain_size_o` (out, 2).
REQ-006 SHALL have ports:
- `lkup_valid_i` (in, 1), `lkup_paddr_i` (in, 32), `lkup_uncached_i` (in, 1): M1 load probe.
- `lkup_data_o` (out, 32), `lkup_mask_o` (out, 4): forwarded bytes and their byte-valid mask.
- `lkup_conflict_o` (out, 1): load must stall.
REQ-007 SHALL have ports `empty_o` (out, 1) and `count_o` (out, $clog2(DEPTH+1)) for barrier/cacop gating.

Function
REQ-010 SHALL be a circular FIFO with head/tail pointers and occupancy count; pointers wrap modulo DEPTH.
REQ-011 `drain_valid_o` SHALL equal (count != 0); payload SHALL be the head entry, and all-zero when empty.
REQ-012 Payload SHALL stay stable while `drain_valid_o` && !`drain_ready_i`; head SHALL advance one entry per handshake.
REQ-013 Coalesce-hit SHALL be asserted when all of the following hold:
- COALESCE=1;
- push cached;
- count >= 2;
- youngest entry cached;
- youngest paddr[31:2] == `push_paddr_i`[31:2].
REQ-014 On an accepted coalesce-hit, the youngest entry's bytes with `push_strobe_i` set SHALL be overwritten, its strobe OR-ed, and count unchanged by the push.
REQ-015 `push_ready_o` SHALL be (count != DEPTH) || coalesce-hit, registered state only; it SHALL have no combinational path from `drain_ready_i`.
REQ-016 Simultaneous push and drain SHALL leave count unchanged (non-coalescing push) or decrement it by one (coalescing push).
REQ-017 When full, a drain in cycle t SHALL make `push_ready_o` high in t+1, not in t.
REQ-018 Uncached entries SHALL never coalesce, and SHALL never be coalesced into; `push_size_i` SHALL be stored and replayed unchanged.
REQ-019 Forwarding SHALL be combinational over registered entries only; a push accepted in cycle t is visible to lookup from t+1.
REQ-020 For each byte lane, `lkup_data_o` SHALL take the youngest valid cached entry whose paddr[31:2] matches and whose strobe bit is set.
REQ-021 `lkup_mask_o` SHALL be the OR of matching strobes; unmatched lanes output 0; all outputs are 0 when `lkup_valid_i` is low.
REQ-022 `lkup_conflict_o` SHALL assert when `lkup_valid_i` and either of the following holds:
- any valid entry is uncached;
- `lkup_uncached_i` and count != 0.
REQ-023 `empty_o` SHALL equal (count == 0); `count_o` SHALL equal count.

Reset
REQ-030 On `rst` at posedge, the following SHALL be zero the next cycle: count, head, tail, all entry valid/strobe bits, `drain_valid_o`, `empty_o` inverse (`empty_o`=1).
REQ-031 Reset mid-operation SHALL discard all entries, including a head stalled in handshake; no drain handshake SHALL complete in the reset cycle.
REQ-032 `push_ready_o` SHALL be 1 the cycle after reset.

Structure
REQ-040 The lsu package SHALL hold typedef `wbuf_entry_t` (paddr, wdata, strobe, uncached, size) and the lookup result struct; DEPTH/COALESCE SHALL remain module parameters.
REQ-041 Byte-lane forwarding SHALL be one combinational sub-module, `core_lsu_wbuf_fwd`, parametrised by DEPTH, taking the entry array plus an age-ordered valid vector.

Verification
REQ-050 Three cached pushes are issued with `drain_ready_i`=0:
- A=0x1000 data 0x11223344 strb 0xF;
- B=0x2000 strb 0x3;
- C=0x2000 data 0xAABB0000 strb 0xC.
Required response: count=2, and the B entry strobe becomes 0xF.
REQ-051 DEPTH=4 is filled with 4 distinct cached words and `drain_ready_i` is pulsed for one cycle. Required response: `push_ready_o` is 0 in the pulse cycle, 1 the next cycle, and count goes 4->3.
REQ-052 Entries 0x3000 strb 0xF data 0x01020304, then 0x3000 uncached, are followed by a cached lookup of 0x3000. Required response: `lkup_conflict_o`=1.
REQ-053 The uncached entry of REQ-052 is drained. Required response:
- the same lookup gives conflict=0, mask=0xF, data=0x01020304;
- an overlapping younger store at lane 0 only changes lane 0.
REQ-054 `drain_ready_i` is held 0 for 5 cycles with head valid. Required response: payload is constant across all 5 cycles.
REQ-055 `rst` is asserted with 3 entries and the head stalled. Required response: the next cycle has count=0, `drain_valid_o`=0, `empty_o`=1, `push_ready_o`=1.
